ds_sc_fifo: RTL
===============

# ds_sc_fifo

Single-clock, parametrised FIFO buffer for the DataStream interface, with an occupancy counter, programmable almost-full/almost-empty flags and a synchronous flush. It is the single-clock counterpart to the dual-clock DataStream FIFO. It supports any depth, not only powers of two, and sits between DataStream producers and consumers in one clock domain, where flow-control look-ahead is needed.

## Interface
Parameters:
- DWIDTH, 8, stream data width (≥1)
- DEPTH, 8, number of storage words (≥2; any integer)
- AFULL, DEPTH-1, almost-full threshold, 0..DEPTH
- AEMPTY, 1, almost-empty threshold, 0..DEPTH
- UWIDTH, $clog2(DEPTH+1), width of the occupancy counter (derived; not overridden)

Ports:
- reset  input  1  asynchronous reset, active low
- clk  input  1  clock; all logic on the rising edge
- flush  input  1  synchronous clear of contents, active high
- i_dat  input  DWIDTH  input stream data
- i_val  input  1  input data valid
- i_rdy  output  1  input ready (FIFO not full)
- o_dat  output  DWIDTH  output stream data (head word)
- o_val  output  1  output data valid (FIFO not empty)
- o_rdy  input  1  output ready
- used  output  UWIDTH  current number of stored words
- afull  output  1  used ≥ AFULL
- aempty  output  1  used ≤ AEMPTY

## Operation
- Storage: DEPTH × DWIDTH array. The write pointer and read pointer each range over 0..DEPTH-1 and wrap explicitly from DEPTH-1 to 0. There is no power-of-two masking.
- Write handshake: wr = i_val & i_rdy. On wr, mem[wp] ← i_dat and wp advances.
- Read handshake: rd = o_val & o_rdy. On rd, rp advances.
- o_dat is mem[rp] (show-ahead). It is valid only while o_val = 1. Its content is unspecified when o_val = 0.
- Count: used_next = used + wr − rd. When wr and rd occur together, used is unchanged and both pointers advance.
- The flags are registers computed from used_next, so all outputs are glitch-free:
  - i_rdy = (used_next ≠ DEPTH)
  - o_val = (used_next ≠ 0)
  - afull = (used_next ≥ AFULL)
  - aempty = (used_next ≤ AEMPTY)
- Full: i_rdy = 0, so no write occurs even if a read happens in the same cycle (no full pass-through). i_rdy returns to 1 on the cycle after the read.
- Empty: o_val = 0. There is no bypass: a word written into an empty FIFO is presented on the following cycle.
- Flush, when flush = 1 at an edge:
  - wp, rp and used are set to 0.
  - Any wr or rd in that cycle is discarded and counts for nothing.
  - After that edge: o_val = 0, i_rdy = 1, aempty = 1, afull = (AFULL == 0).
- Reset, when reset = 0 (asynchronous, any time, including mid-transfer):
  - Pointers and used are set to 0 immediately.
  - o_val = 0, i_rdy = 1, used = 0, aempty = 1, afull = (AFULL == 0).
  - Memory contents are not cleared.
- Arithmetic: pointer increments compare against DEPTH-1 before wrapping. used never exceeds DEPTH and never goes below 0, by construction of the handshakes.

## Timing
- Write-to-output latency is 1 cycle. A word accepted at edge k gives o_val = 1 and o_dat = that word after edge k, when the FIFO was empty.
- Read-to-ready latency is 1 cycle. A read at edge k from a full FIFO gives i_rdy = 1 after edge k.
- Throughput is one write and one read per cycle sustained, whenever the FIFO is neither full nor empty.
- used, afull and aempty reflect the handshakes of edge k immediately after edge k.
- Flush takes effect at the edge it is sampled on, with 1-cycle latency to the outputs.
- Reset is asynchronous assert and synchronous-safe release. Outputs take their reset values combinationally on assertion.

## Test plan
- Fill/drain, DEPTH=5, AFULL=4, AEMPTY=1. Write 0x01..0x05 with o_rdy = 0:
  - used counts 1..5; afull rises after the 4th write; i_rdy = 0 after the 5th.
  - A 6th i_val is not accepted.
  - Then drain with o_rdy = 1: o_dat = 0x01..0x05 in order, and o_val = 0 after the 5th read.
- Wrap-around, DEPTH=5. Run 23 words with continuous simultaneous i_val = o_rdy = 1 at used = 2:
  - used stays 2.
  - Output order matches input across multiple pointer wraps.
- Full with simultaneous read. At used = 5, assert i_val = 1 and o_rdy = 1:
  - No write; used becomes 4 and i_rdy = 1 on the next cycle.
  - The blocked word is accepted on the following edge.
- Flush. With used = 3, assert flush together with i_val = 1 and o_rdy = 1:
  - Next cycle: used = 0, o_val = 0, aempty = 1, i_rdy = 1.
  - A subsequent write of 0xA5 appears on o_dat 1 cycle later.
- Reset mid-operation. Assert reset low at used = 4 between edges:
  - Outputs immediately show o_val = 0, used = 0, i_rdy = 1.
  - After release, a new stream 0x10, 0x11 comes out in order, with no stale data.
- Random back-pressure, DWIDTH=16, DEPTH=8, 10k cycles of random i_val and o_rdy. Check against a scoreboard:
  - No loss or duplication.
  - used equals the model count.
  - Every flag equals its threshold equation on every cycle.

Source files
------------

// File: rtl/ds_sc_fifo.sv
// Single-clock DataStream FIFO for any depth (not just powers of two), with an
// occupancy count, almost-full/almost-empty flags and synchronous flush.
module ds_sc_fifo #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 8,
  parameter int AFULL  = DEPTH - 1,
  parameter int AEMPTY = 1,
  parameter int UWIDTH = $clog2(DEPTH + 1)
) (
  input  logic              reset,
  input  logic              clk,
  input  logic              flush,
  input  logic [DWIDTH-1:0] i_dat,
  input  logic              i_val,
  output logic              i_rdy,
  output logic [DWIDTH-1:0] o_dat,
  output logic              o_val,
  input  logic              o_rdy,
  output logic [UWIDTH-1:0] used,
  output logic              afull,
  output logic              aempty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0]     LAST_PTR  = PW'(DEPTH - 1);
  localparam logic [UWIDTH-1:0] DEPTH_U   = UWIDTH'(DEPTH);
  localparam logic [UWIDTH-1:0] AFULL_U   = UWIDTH'(AFULL);
  localparam logic [UWIDTH-1:0] AEMPTY_U  = UWIDTH'(AEMPTY);
  localparam logic              AFULL_RST = (AFULL == 0);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]     wp;
  logic [PW-1:0]     rp;
  logic [UWIDTH-1:0] used_next;
  logic              wr;
  logic              rd;

  assign wr    = i_val & i_rdy;
  assign rd    = o_val & o_rdy;
  assign o_dat = mem[rp];

  // Flags are registered from the next count so they change cleanly at the edge.
  always_comb begin
    used_next = used;
    if (flush)
      used_next = '0;
    else if (wr && !rd)
      used_next = used + 1'b1;
    else if (rd && !wr)
      used_next = used - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp     <= '0;
      rp     <= '0;
      used   <= '0;
      i_rdy  <= 1'b1;
      o_val  <= 1'b0;
      afull  <= AFULL_RST;
      aempty <= 1'b1;
    end else begin
      if (flush) begin
        wp <= '0;
        rp <= '0;
      end else begin
        if (wr)
          wp <= (wp == LAST_PTR) ? '0 : wp + 1'b1;
        if (rd)
          rp <= (rp == LAST_PTR) ? '0 : rp + 1'b1;
      end
      used   <= used_next;
      i_rdy  <= (used_next != DEPTH_U);
      o_val  <= (used_next != '0);
      afull  <= (used_next >= AFULL_U);
      aempty <= (used_next <= AEMPTY_U);
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr && !flush)
      mem[wp] <= i_dat;
  end

endmodule
